vga_plot_sink: RTL and testbench

- Receiving end of the plot interface (x, y, colour, plot) that the drawing FSMs drive.
- Accepts pixel-write requests into a small FIFO, range-checks each one, and converts (x,y) to a linear framebuffer address (y*H_RES + x).
- Issues one memory write per pixel on a ready/we handshake to the framebuffer memory port.
- Sits between the drawing datapaths and framebuffer memory, so drawers never stall on memory.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_plot_sink_if.sv | 26 ++
 rtl/vga_plot_fifo.sv | 60 ++++++
 rtl/vga_plot_sink.sv | 124 ++++++++++++
 tb/tb_vga_plot_sink.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared defaults, pixel request type and engine states for the plot sink.
package vga_pkg;

    localparam int unsigned H_RES    = 160;
    localparam int unsigned V_RES    = 120;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_req_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE
    } engine_state_t;

endpackage

// File: rtl/vga_plot_sink_if.sv
// Plot request channel from the drawers plus the framebuffer write port.
interface vga_plot_sink_if #(
    parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W,
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W
);
    logic                     plot;
    logic [vga_pkg::X_W-1:0]  x;
    logic [vga_pkg::Y_W-1:0]  y;
    logic [COLOUR_W-1:0]      colour;
    logic                     plot_ready;

    logic [ADDR_W-1:0]        mem_addr;
    logic [COLOUR_W-1:0]      mem_data;
    logic                     mem_we;
    logic                     mem_ready;

    modport master (
        output plot, x, y, colour, mem_ready,
        input  plot_ready, mem_addr, mem_data, mem_we
    );

    modport slave (
        input  plot, x, y, colour, mem_ready,
        output plot_ready, mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/vga_plot_fifo.sv
// Synchronous FIFO with occupancy count; a push is refused while full even if a pop happens.
module vga_plot_fifo
    import vga_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = X_W + Y_W + COLOUR_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_sink.sv
// Queues pixel writes, clips off-screen pixels and writes y*H_RES+x to the framebuffer.
// Optional VGA_PLOT_SINK_CLIP_COUNT_EN adds a saturating count of clipped pixels.
module vga_plot_sink #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned H_RES    = vga_pkg::H_RES,
    parameter int unsigned V_RES    = vga_pkg::V_RES,
    parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W,
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    vga_plot_sink_if.slave        bus,
`ifdef VGA_PLOT_SINK_CLIP_COUNT_EN
    output logic [15:0]           clip_count,
`endif
    output logic                  busy
);
    import vga_pkg::*;

    localparam int unsigned ENT_W = X_W + Y_W + COLOUR_W;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ENT_W-1:0] fifo_out;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;

    engine_state_t       state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
    logic                in_range;

    vga_plot_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (bus.plot),
        .data_i  ({bus.x, bus.y, bus.colour}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.plot_ready = !fifo_full;
    assign busy           = (fifo_count != '0) || (state_q != IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.mem_we     = (state_q == WRITE);

    assign in_range = (32'(x_q) < H_RES) && (32'(y_q) < V_RES);

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop              = 1'b1;
                    {x_d, y_d, colour_d}  = fifo_out;
                    state_d               = CHECK;
                end
            end
            CHECK: begin
                if (in_range) begin
                    mem_addr_d = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);
                    mem_data_d = colour_q;
                    state_d    = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

`ifdef VGA_PLOT_SINK_CLIP_COUNT_EN
    logic [15:0] clip_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            clip_cnt_q <= '0;
        end else if ((state_q == CHECK) && !in_range && (clip_cnt_q != '1)) begin
            clip_cnt_q <= clip_cnt_q + 16'd1;
        end
    end

    assign clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_vga_plot_sink.sv
// Scoreboard bench for vga_plot_sink: a reference model predicts each framebuffer write.
module tb_vga_plot_sink;
    import vga_pkg::*;

    localparam int MODEL_H = 160;
    localparam int MODEL_V = 120;

    typedef struct {
        logic [14:0] addr;
        logic [2:0]  data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
`ifdef VGA_PLOT_SINK_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    logic fixed_ready = 1'b1;
    logic rand_ready  = 1'b0;
    logic rnd_bit     = 1'b0;

    wr_t exp_q[$];
    int  checks      = 0;
    int  errors      = 0;
    int  writes_seen = 0;
    int  clips_exp   = 0;

    vga_plot_sink_if #(.COLOUR_W(3), .ADDR_W(15)) bus();

    vga_plot_sink #(
        .DEPTH    (4),
        .H_RES    (160),
        .V_RES    (120),
        .COLOUR_W (3),
        .ADDR_W   (15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
`ifdef VGA_PLOT_SINK_CLIP_COUNT_EN
        .clip_count (clip_count),
`endif
        .busy       (busy)
    );

    always #10 clock = ~clock;

    always @(posedge clock) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    assign bus.mem_ready = rand_ready ? rnd_bit : fixed_ready;

    // Monitor: every accepted write must match the oldest predicted one.
    always @(negedge clock) begin : monitor
        wr_t e;
        if (!reset && bus.mem_we && bus.mem_ready) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                         bus.mem_addr, bus.mem_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_data !== e.data) begin
                    errors++;
                    $display("FAIL write_data: got addr %0d data %0d, required addr %0d data %0d",
                             bus.mem_addr, bus.mem_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference model: on-screen pixels become one write at row*width+column.
    function automatic void model(input pixel_req_t p);
        wr_t w;
        if (int'(p.x) < MODEL_H && int'(p.y) < MODEL_V) begin
            w.addr = 15'(int'(p.y) * MODEL_H + int'(p.x));
            w.data = p.colour;
            exp_q.push_back(w);
        end else begin
            clips_exp++;
        end
    endfunction

    function automatic pixel_req_t mk(input int px, input int py, input int pc);
        pixel_req_t p;
        p.x      = 8'(px);
        p.y      = 7'(py);
        p.colour = 3'(pc);
        return p;
    endfunction

    function automatic pixel_req_t rand_px(input int xmax, input int ymax);
        return mk(int'($urandom_range(0, xmax)), int'($urandom_range(0, ymax)),
                  int'($urandom_range(0, 7)));
    endfunction

    task automatic push(input pixel_req_t p);
        int n = 0;
        bus.plot   = 1'b1;
        bus.x      = p.x;
        bus.y      = p.y;
        bus.colour = p.colour;
        forever begin
            @(negedge clock);
            if (bus.plot_ready) break;
            n++;
            if (n > 500) begin
                errors++;
                $display("FAIL push_timeout: plot_ready stayed 0, required 1");
                break;
            end
        end
        if (n <= 500) model(p);
        @(posedge clock);
        #1;
        bus.plot = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_done", 32'((exp_q.size() == 0) && !busy), 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pixel_req_t p;
        int acc, w0, first_block;

        bus.plot   = 1'b0;
        bus.x      = '0;
        bus.y      = '0;
        bus.colour = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        @(negedge clock);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plot_ready", 32'(bus.plot_ready), 32'd1);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_data", 32'(bus.mem_data), 32'd0);
`ifdef VGA_PLOT_SINK_CLIP_COUNT_EN
        check("rst_clip_count", 32'(clip_count), 32'd0);
`endif
        @(posedge clock);
        #1;

        // Single pixel latency: write strobe in the third cycle after the push edge.
        push(mk(5, 7, 5));
        @(negedge clock);
        check("lat_n1_we", 32'(bus.mem_we), 32'd0);
        @(negedge clock);
        check("lat_n2_we", 32'(bus.mem_we), 32'd0);
        @(negedge clock);
        check("lat_n3_we", 32'(bus.mem_we), 32'd1);
        check("lat_n3_addr", 32'(bus.mem_addr), 32'd1125);
        check("lat_n3_data", 32'(bus.mem_data), 32'd5);
        @(negedge clock);
        check("lat_n4_we", 32'(bus.mem_we), 32'd0);
        check("lat_n4_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;

        // Corner addresses and back-to-back ordering.
        push(mk(0, 0, 2));
        push(mk(159, 119, 7));
        for (int i = 0; i < 4; i++) push(mk(40 + i * 3, 60, i + 1));
        drain();

        // Clipping.
        w0 = writes_seen;
        clips_exp = 0;
        push(mk(160, 0, 1));
        push(mk(0, 120, 1));
        push(mk(2, 1, 6));
        drain();
        check("clip_writes", 32'(writes_seen - w0), 32'd1);
`ifdef VGA_PLOT_SINK_CLIP_COUNT_EN
        check("clip_count", 32'(clip_count), 32'(clips_exp));
`endif

        // Back-pressure: DEPTH queued plus one held in the engine.
        fixed_ready = 1'b0;
        acc = 0;
        first_block = -1;
        p = rand_px(MODEL_H - 1, MODEL_V - 1);
        bus.plot   = 1'b1;
        bus.x      = p.x;
        bus.y      = p.y;
        bus.colour = p.colour;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.plot_ready) begin
                model(p);
                acc++;
                p = rand_px(MODEL_H - 1, MODEL_V - 1);
            end else if (first_block < 0) begin
                first_block = i;
            end
            @(posedge clock);
            #1;
            bus.x      = p.x;
            bus.y      = p.y;
            bus.colour = p.colour;
        end
        bus.plot = 1'b0;
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_first_block", 32'(first_block), 32'd5);
        w0 = writes_seen;
        fixed_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.plot_ready) break;
        end
        check("bp_ready_after_first_pop", 32'(writes_seen - w0), 32'd1);
        @(posedge clock);
        #1;
        drain();
        check("bp_writes", 32'(writes_seen - w0), 32'd5);

        // Randomised traffic with a jittering memory ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) push(rand_px(175, 127));
        drain();
        rand_ready = 1'b0;

        // Reset in the middle of a stalled write with three pixels queued.
        fixed_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(mk(20 + i, 30, i));
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.mem_we) break;
        end
        check("rst_mid_we_before", 32'(bus.mem_we), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        clips_exp = 0;
        @(negedge clock);
        check("rst_mid_we", 32'(bus.mem_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_plot_ready", 32'(bus.plot_ready), 32'd1);
        fixed_ready = 1'b1;
        w0 = writes_seen;
        repeat (20) @(negedge clock);
        check("rst_mid_no_writes", 32'(writes_seen - w0), 32'd0);
        @(posedge clock);
        #1;

`ifdef VGA_PLOT_SINK_CLIP_COUNT_EN
        check("rst_mid_clip_count", 32'(clip_count), 32'd0);
        // Preload near the top so saturation is reached in a few drops.
        force dut.clip_cnt_q = 16'hFFFD;
        @(posedge clock);
        #1;
        release dut.clip_cnt_q;
        for (int i = 0; i < 6; i++) push(mk(200, 0, 1));
        drain();
        check("clip_saturate", 32'(clip_count), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
